// File: rtl/feature_func_unit_pkg.sv
// Shared encodings for the feature function unit: lane-function modes,
// FSM state type and the default lane width.
package feature_func_pkg;
  localparam int LANE_W_DEF = 8;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_BIAS = 2'd2;
  localparam logic [1:0] MODE_RELU = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/feature_func_unit_if.sv
// Feature stream bus: upstream valid/ready input side plus the registered
// downstream output side. The unit itself uses the slave modport.
interface feature_func_unit_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] I_feature_in;
  logic              I_feature_dv;
  logic              O_feature_rdy;
  logic [DATA_W-1:0] O_feature_out;
  logic              O_feature_dv;
  logic              I_feature_rdy;

  modport slave (
    input  I_feature_in, I_feature_dv, I_feature_rdy,
    output O_feature_rdy, O_feature_out, O_feature_dv
  );

  modport master (
    output I_feature_in, I_feature_dv, I_feature_rdy,
    input  O_feature_rdy, O_feature_out, O_feature_dv
  );
endinterface

// File: rtl/feature_func_unit_lane_op.sv
// Single-lane combinational function: pass, invert, saturating bias add, ReLU.
module feature_lane_op
  import feature_func_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [1:0]        i_mode,
  input  logic [LANE_W-1:0] i_bias,
  input  logic [LANE_W-1:0] i_lane,
  output logic [LANE_W-1:0] o_lane
);
  logic [LANE_W:0] w_sum;

  // Extra carry bit stays inside this lane and only selects saturation.
  assign w_sum = {1'b0, i_lane} + {1'b0, i_bias};

  always_comb begin
    o_lane = i_lane;
    case (i_mode)
      MODE_PASS: o_lane = i_lane;
      MODE_INV:  o_lane = ~i_lane;
      MODE_BIAS: o_lane = w_sum[LANE_W] ? {LANE_W{1'b1}} : w_sum[LANE_W-1:0];
      MODE_RELU: o_lane = i_lane[LANE_W-1] ? '0 : i_lane;
      default:   o_lane = i_lane;
    endcase
  end
endmodule

// File: rtl/feature_func_unit.sv
// Framed feature-stream function unit: job FSM, beat counter, latched config
// and a one-deep output register with valid/ready backpressure.
module feature_func_unit
  import feature_func_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int LANE_W = LANE_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              I_aclk,
  input  logic              I_arst,
  input  logic              I_start,
  input  logic [1:0]        I_mode,
  input  logic [LANE_W-1:0] I_bias,
  input  logic [CNT_W-1:0]  I_beat_num,
  output logic              O_busy,
  output logic              O_done,
  feature_func_unit_if.slave s_if
);
  localparam int LANES = DATA_W / LANE_W;

  state_t                       r_state, w_state_nxt;
  logic [1:0]                   r_mode;
  logic [LANE_W-1:0]            r_bias;
  logic [CNT_W-1:0]             r_beat_num, r_cnt, w_cnt_inc;
  logic [DATA_W-1:0]            r_out;
  logic                         r_dv, r_done;
  logic                         w_rdy, w_acc, w_hs, w_latch, w_done_nxt;
  logic [LANES-1:0][LANE_W-1:0] w_func;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    feature_lane_op #(.LANE_W(LANE_W)) u_op (
      .i_mode (r_mode),
      .i_bias (r_bias),
      .i_lane (s_if.I_feature_in[g*LANE_W +: LANE_W]),
      .o_lane (w_func[g])
    );
  end

  assign w_rdy     = (r_state == ST_RUN) && (!r_dv || s_if.I_feature_rdy);
  assign w_acc     = s_if.I_feature_dv && w_rdy;
  assign w_hs      = r_dv && s_if.I_feature_rdy;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: if (I_start) begin
        w_latch = 1'b1;
        if (I_beat_num != '0) w_state_nxt = ST_RUN;
        else                  w_done_nxt  = 1'b1;
      end
      ST_RUN: if (w_acc && (w_cnt_inc == r_beat_num)) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (!r_dv || w_hs) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_aclk) begin
    if (I_arst) begin
      r_state    <= ST_IDLE;
      r_mode     <= '0;
      r_bias     <= '0;
      r_beat_num <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_dv       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_latch) begin
        r_mode     <= I_mode;
        r_bias     <= I_bias;
        r_beat_num <= I_beat_num;
        r_cnt      <= '0;
      end else if (w_acc) begin
        r_cnt <= w_cnt_inc;
      end
      // Accept wins over drain: a beat arriving on a handshake replaces the old one.
      if (w_acc) begin
        r_out <= w_func;
        r_dv  <= 1'b1;
      end else if (w_hs) begin
        r_dv  <= 1'b0;
      end
    end
  end

  assign s_if.O_feature_rdy = w_rdy;
  assign s_if.O_feature_out = r_out;
  assign s_if.O_feature_dv  = r_dv;
  assign O_busy             = (r_state != ST_IDLE);
  assign O_done             = r_done;
endmodule

// File: doc/feature_func_unit.md
# feature_func_unit

Parametrised successor to the single-stage feature inverter on the 128-bit feature stream. It applies a per-job selectable lane-wise function to a framed burst of feature beats: pass, invert, saturating bias add or ReLU. It adds valid/ready backpressure, a beat counter armed by `I_start`, and a completion pulse. It sits inline between the AXI feature reader and the downstream compute stage.

## Interface
- `DATA_W`, default 128: feature beat width; must be an integer multiple of `LANE_W`.
- `LANE_W`, default 8: lane width; `LANES = DATA_W/LANE_W`.
- `CNT_W`, default 16: beat-count width.
- `I_aclk`, in, 1: sole clock; all logic on the rising edge.
- `I_arst`, in, 1: synchronous, active-high reset.
- `I_start`, in, 1: single-cycle job start; honoured only in IDLE.
- `I_mode`, in, 2: function select, latched at start.
- `I_bias`, in, `LANE_W`: unsigned bias for mode 2, latched at start.
- `I_beat_num`, in, `CNT_W`: beats in the job, latched at start.
- `I_feature_in`, in, `DATA_W`: input beat.
- `I_feature_dv`, in, 1: input valid.
- `O_feature_rdy`, out, 1: input ready.
- `O_feature_out`, out, `DATA_W`: result beat (registered).
- `O_feature_dv`, out, 1: output valid.
- `I_feature_rdy`, in, 1: downstream ready.
- `O_busy`, out, 1: high in RUN and FLUSH.
- `O_done`, out, 1: one-cycle job completion pulse (registered).

## Operation
- FSM with three states: IDLE, RUN, FLUSH.
- IDLE:
  - `O_feature_rdy = 0`; input beats are ignored.
  - On `I_start`, latch mode, bias and beat count, and clear the beat counter.
  - If `I_beat_num != 0`, go to RUN.
  - If `I_beat_num == 0`, stay in IDLE and pulse `O_done` in the next cycle.
- RUN:
  - `O_feature_rdy = !O_feature_dv | I_feature_rdy`.
  - An input is accepted when `I_feature_dv & O_feature_rdy`; the counter increments per accept.
  - On the accept that brings the count to the latched beat number, go to FLUSH.
- FLUSH:
  - `O_feature_rdy = 0`.
  - When the output register is empty, or empties this cycle via handshake, go to IDLE and pulse `O_done`.
- `I_start` outside IDLE is ignored; the latched config is unchanged.
- Lane functions, applied to each `LANE_W` slice independently:
  - Mode 0: pass-through.
  - Mode 1: bitwise invert, matching the legacy behaviour.
  - Mode 2: unsigned add of `I_bias`, saturating at `2^LANE_W-1`; the carry never crosses lanes.
  - Mode 3: signed ReLU; a lane with MSB set becomes 0, otherwise it passes.
- Output register:
  - Loads on accept.
  - Holds value and `O_feature_dv` while `O_feature_dv & !I_feature_rdy`.
  - Clears `O_feature_dv` on a handshake with no new accept.
- Reset at any time:
  - FSM returns to IDLE; counter and latched config go to 0.
  - `O_feature_out = 0`; `O_feature_dv`, `O_feature_rdy`, `O_busy` and `O_done` go to 0.
  - An in-flight beat is dropped.

## Timing
- Latency: a beat accepted at edge k drives `O_feature_dv` and its result from edge k onward, i.e. it is visible in cycle k+1.
- Throughput: one beat per cycle while `I_feature_rdy` is held high.
- `O_feature_rdy` depends combinationally on `I_feature_rdy`; this is the only combinational path through the block.
- `O_busy` rises on the edge that samples a valid `I_start` (count non-zero).
- `O_busy` falls on the same edge at which `O_done` rises.
- `O_done` is high for exactly one cycle, the cycle after the last output handshake.
- A new `I_start` in the `O_done` cycle is accepted, since the FSM is already in IDLE.
- Counter width: the maximum job length is `2^CNT_W-1` beats; the counter never wraps within a job.

## Structure
- Package `feature_func_pkg` holds:
  - mode encodings: `MODE_PASS=0`, `MODE_INV=1`, `MODE_BIAS=2`, `MODE_RELU=3`;
  - the FSM state type;
  - the default `LANE_W`.
- Sub-module `feature_lane_op` is a purely combinational single-lane function (mode, bias, lane in -> lane out). It is instantiated `LANES` times via generate.
- Top level holds the FSM, counter, config latches and output register.

## Test plan
- Mode 1, beat_num=2, inputs `0x00..00` then `0xFF..FF`, downstream always ready:
  - outputs are `0xFF..FF` then `0x00..00` at latency 1;
  - `O_done` pulses one cycle after the 2nd output.
- Mode 2, bias `0x10`, lanes `0x05` and `0xF8`:
  - lanes become `0x15` and `0xFF` (saturated);
  - neighbouring lanes are unaffected.
- Mode 3, lanes `0x7F` and `0x80`: output lanes are `0x7F` and `0x00`.
- Mode 0, beat_num=4, `I_feature_rdy` toggling 1,0,0,1,…:
  - output is held stable while stalled;
  - no beat is lost or duplicated;
  - exactly 4 output handshakes, then `O_done`.
- `I_start` with beat_num=0: `O_done` pulses the next cycle, `O_busy` stays 0, and `O_feature_rdy` never asserts.
- Assert `I_arst` mid-job with `O_feature_dv=1`:
  - the next cycle shows all outputs 0, IDLE, and no `O_done`;
  - a fresh `I_start` then runs a job correctly.
